gen_seq_unico: RTL

//  Parametrised generator of non-repeating pseudo-random sequences for the memory-test game.
//  - Fills a DEPTH-entry register file with distinct values in 1..MAXVAL on a start pulse.
//  - Exposes the stored sequence on a combinational read port for the display/compare path.
//  - Successor to the fixed 9-digit generator:
//    - width, depth and range are parametric;
//    - the repeat check covers only the valid entries;
//    - busy/done status is exposed;
//    - the entropy gate is explicit.

---
 rtl/gen_seq_unico_if.sv | 26 ++
 rtl/gen_seq_unico.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/gen_seq_unico_if.sv
// Handshake/read bundle for gen_seq_unico; master drives controls, slave is the generator.
interface gen_seq_unico_if #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 9
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          i_start;
    logic          i_clear;
    logic          i_ent_tick;
    logic [AW-1:0] i_rd_addr;
    logic [W-1:0]  o_rd_data;
    logic [AW:0]   o_count;
    logic          o_busy;
    logic          o_done;

    modport master (
        output i_start, i_clear, i_ent_tick, i_rd_addr,
        input  o_rd_data, o_count, o_busy, o_done
    );

    modport slave (
        input  i_start, i_clear, i_ent_tick, i_rd_addr,
        output o_rd_data, o_count, o_busy, o_done
    );
endinterface

// File: rtl/gen_seq_unico.sv
// Non-repeating pseudo-random sequence generator (DEPTH distinct values in 1..MAXVAL).
// Optional GEN_LFSR_EN adds a 16-bit Galois LFSR as the sample source.
module gen_seq_unico #(
    parameter int unsigned W      = 4,
    parameter int unsigned DEPTH  = 9,
    parameter int unsigned MAXVAL = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    gen_seq_unico_if.slave    io_bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 1) begin : g_chk_depth
        $error("gen_seq_unico: DEPTH must be >= 1");
    end
    if (MAXVAL < DEPTH) begin : g_chk_range
        $error("gen_seq_unico: MAXVAL must be >= DEPTH");
    end
    if (MAXVAL >= (2 ** W)) begin : g_chk_width
        $error("gen_seq_unico: 2**W must exceed MAXVAL");
    end

    typedef enum logic [1:0] {StIdle, StCheck, StDone} state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_count;
    logic [W-1:0]  r_cand;
    logic [W-1:0]  r_cnt;
    logic [W-1:0]  w_smp;
    logic [W-1:0]  w_cand_inc;
    logic [AW:0]   w_count_inc;
    logic [AW-1:0] w_wr_idx;
    logic          w_last;
    logic          w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= W'(1);
        end else if (io_bus.i_ent_tick) begin
            r_cnt <= (r_cnt == W'(MAXVAL)) ? W'(1) : r_cnt + W'(1);
        end
    end

`ifdef GEN_LFSR_EN
    logic [15:0]  r_lfsr;
    logic [W-1:0] w_lfsr_val;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign w_lfsr_val = r_lfsr[W-1:0];
    assign w_smp      = (w_lfsr_val != '0 && w_lfsr_val <= W'(MAXVAL)) ? w_lfsr_val : r_cnt;
`else
    assign w_smp = r_cnt;
`endif

    assign w_cand_inc  = (r_cand == W'(MAXVAL)) ? W'(1) : r_cand + W'(1);
    assign w_count_inc = r_count + (AW+1)'(1);
    assign w_wr_idx    = r_count[AW-1:0];
    assign w_last      = (w_count_inc == (AW+1)'(DEPTH));

    // Only the entries written in the current run take part in the repeat check.
    always_comb begin
        w_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (((AW+1)'(i) < r_count) && (r_mem[i] == r_cand)) w_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (io_bus.i_start) w_state_nxt = StCheck;
            StCheck: if (!w_hit && w_last) w_state_nxt = StDone;
            StDone:  if (io_bus.i_start) w_state_nxt = StCheck;
            default: w_state_nxt = StIdle;
        endcase
        if (io_bus.i_clear) w_state_nxt = StIdle;
    end

    always_comb begin
        io_bus.o_busy = 1'b0;
        io_bus.o_done = 1'b0;
        case (r_state)
            StCheck: io_bus.o_busy = 1'b1;
            StDone:  io_bus.o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_count <= '0;
            r_cand  <= '0;
        end else if (io_bus.i_clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (io_bus.i_start) begin
                        r_cand  <= w_smp;
                        r_count <= '0;
                    end
                end
                StCheck: begin
                    if (w_hit) begin
                        r_cand <= w_cand_inc;
                    end else begin
                        r_mem[w_wr_idx] <= r_cand;
                        r_count         <= w_count_inc;
                        if (!w_last) r_cand <= w_smp;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        io_bus.o_rd_data = '0;
        if ({1'b0, io_bus.i_rd_addr} < (AW+1)'(DEPTH)) io_bus.o_rd_data = r_mem[io_bus.i_rd_addr];
    end

    assign io_bus.o_count = r_count;
endmodule
